// File: rtl/quantum_scheduler_pkg.sv
// quantum_scheduler_pkg: shared state, next-PC select and swap-cause encodings
package quantum_scheduler_pkg;
  typedef enum logic {OS_RUN, USER_RUN} state_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_QUANTUM, CAUSE_SYSCALL} cause_t;
  localparam logic [2:0] SEL_PC1 = 3'd0;
  localparam logic [2:0] SEL_REG = 3'd1;
  localparam logic [2:0] SEL_IMM = 3'd2;
  localparam logic [2:0] SEL_DESV = 3'd3;
  localparam logic [2:0] SEL_RET = 3'd4;
  localparam logic [31:0] OS_ENTRY = 32'd96;
endpackage

// File: rtl/quantum_scheduler_if.sv
// quantum_scheduler_if: decoder-side controls in, next-PC mux controls out
interface quantum_scheduler_if #(parameter int QW = 16) ();
  logic instr_valid;
  logic [2:0] jump_ctrl;
  logic [31:0] pc_next_cand;
  logic syscall;
  logic proc_resume;
  logic quantum_load;
  logic [QW-1:0] quantum_value;
  logic swap_so;
  logic [2:0] mux_ctrl;
  logic [31:0] end_ret;
  logic user_mode;
  logic [1:0] swap_cause;
  modport master (
    output instr_valid, jump_ctrl, pc_next_cand, syscall, proc_resume, quantum_load, quantum_value,
    input swap_so, mux_ctrl, end_ret, user_mode, swap_cause
  );
  modport slave (
    input instr_valid, jump_ctrl, pc_next_cand, syscall, proc_resume, quantum_load, quantum_value,
    output swap_so, mux_ctrl, end_ret, user_mode, swap_cause
  );
endinterface

// File: rtl/quantum_scheduler_counter.sv
// quantum_counter: remaining-instruction counter with load, clear, decrement and one-detect
module quantum_counter #(parameter int QW = 16) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic          dec,
  input  logic [QW-1:0] load_val,
  output logic          is_one
);
  logic [QW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign is_one = cnt == QW'(1);
endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: preemptive time-slice control of the next-PC mux (OS entry / return-to-process)
module quantum_scheduler
  import quantum_scheduler_pkg::*;
#(
  parameter int QW = 16,
  parameter int DEFAULT_QUANTUM = 100
) (
  input logic clk,
  input logic rst,
  quantum_scheduler_if.slave bus
);
  state_t state;
  logic [QW-1:0] quantum_reg;
  logic is_one, user_instr, expire, swap, resume;
  assign user_instr = state == USER_RUN && bus.instr_valid;
  // A zero quantum disables timer preemption; only syscalls can swap.
  assign expire = quantum_reg != '0 && is_one;
  assign swap = user_instr && (bus.syscall || expire);
  assign resume = state == OS_RUN && bus.instr_valid && bus.proc_resume;
  assign bus.swap_so = swap;
  assign bus.mux_ctrl = resume ? SEL_RET : bus.jump_ctrl;
  assign bus.user_mode = state == USER_RUN;
  quantum_counter #(.QW(QW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(resume),
    .clr(swap),
    .dec(user_instr),
    .load_val(quantum_reg),
    .is_one(is_one)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OS_RUN;
      quantum_reg <= QW'(DEFAULT_QUANTUM);
      bus.end_ret <= '0;
      bus.swap_cause <= CAUSE_NONE;
    end else begin
      if (bus.quantum_load) quantum_reg <= bus.quantum_value;
      if (resume) state <= USER_RUN;
      if (swap) begin
        state <= OS_RUN;
        bus.end_ret <= bus.pc_next_cand;
        bus.swap_cause <= bus.syscall ? CAUSE_SYSCALL : CAUSE_QUANTUM;
      end
    end
  end
endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: directed vector table plus hand-written slice sequences
module tb_quantum_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  quantum_scheduler_if #(.QW(16)) bus ();
  quantum_scheduler #(.QW(16), .DEFAULT_QUANTUM(100)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic iv;
    logic [2:0] jc;
    logic [31:0] pc;
    logic sc, pr, ql;
    logic [15:0] qv;
    logic e_swap;
    logic [2:0] e_mux;
    logic e_user;
    logic [1:0] e_cause;
    logic [31:0] e_ret;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  task automatic apply(input logic iv, input logic [2:0] jc, input logic [31:0] pc,
                       input logic sc, input logic pr, input logic ql, input logic [15:0] qv);
    @(negedge clk);
    bus.instr_valid = iv;
    bus.jump_ctrl = jc;
    bus.pc_next_cand = pc;
    bus.syscall = sc;
    bus.proc_resume = pr;
    bus.quantum_load = ql;
    bus.quantum_value = qv;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.instr_valid = 0;
    bus.syscall = 0;
    bus.proc_resume = 0;
    bus.quantum_load = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int r, swaps;
    logic iv;
    bus.instr_valid = 0; bus.jump_ctrl = 0; bus.pc_next_cand = 0; bus.syscall = 0;
    bus.proc_resume = 0; bus.quantum_load = 0; bus.quantum_value = 0;
    vt[0]  = '{1'b0, 3'd2, 32'd0,   1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 3'd2, 1'b0, 2'd0, 32'd0};
    vt[1]  = '{1'b1, 3'd0, 32'd0,   1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd4, 1'b0, 2'd0, 32'd0};
    vt[2]  = '{1'b1, 3'd0, 32'd201, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b1, 2'd0, 32'd0};
    vt[3]  = '{1'b1, 3'd2, 32'd202, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd2, 1'b1, 2'd0, 32'd0};
    vt[4]  = '{1'b1, 3'd0, 32'd203, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b1, 2'd0, 32'd0};
    vt[5]  = '{1'b1, 3'd1, 32'd204, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd1, 1'b1, 2'd0, 32'd0};
    vt[6]  = '{1'b1, 3'd0, 32'd205, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 3'd0, 1'b1, 2'd0, 32'd0};
    vt[7]  = '{1'b0, 3'd1, 32'd0,   1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 3'd1, 1'b0, 2'd1, 32'd205};
    vt[8]  = '{1'b1, 3'd3, 32'd0,   1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd4, 1'b0, 2'd1, 32'd205};
    vt[9]  = '{1'b1, 3'd1, 32'd300, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 3'd1, 1'b1, 2'd1, 32'd205};
    vt[10] = '{1'b1, 3'd1, 32'd301, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 3'd1, 1'b1, 2'd1, 32'd205};
    vt[11] = '{1'b1, 3'd0, 32'd0,   1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 2'd2, 32'd301};
    do_reset();
    apply(0, 3'd2, 0, 0, 0, 0, 0);
    chk("rst_user", bus.user_mode, 0);
    chk("rst_end_ret", bus.end_ret, 0);
    chk("rst_cause", bus.swap_cause, 0);
    chk("rst_mux", bus.mux_ctrl, 2);
    for (int i = 0; i < 20; i++) begin
      apply(1, 3'(i % 4), 32'(i), 1'(i % 2), 0, 0, 0);
      chk("os_swap", bus.swap_so, 0);
      chk("os_mux", bus.mux_ctrl, 32'(i % 4));
    end
    for (int i = 0; i < 12; i++) begin
      apply(vt[i].iv, vt[i].jc, vt[i].pc, vt[i].sc, vt[i].pr, vt[i].ql, vt[i].qv);
      chk($sformatf("v%0d_swap", i), bus.swap_so, vt[i].e_swap);
      chk($sformatf("v%0d_mux", i), bus.mux_ctrl, vt[i].e_mux);
      chk($sformatf("v%0d_user", i), bus.user_mode, vt[i].e_user);
      chk($sformatf("v%0d_cause", i), bus.swap_cause, vt[i].e_cause);
      chk($sformatf("v%0d_ret", i), bus.end_ret, vt[i].e_ret);
    end
    apply(1, 0, 0, 0, 1, 0, 0);
    r = 0;
    for (int k = 0; k < 10; k++) begin
      iv = (k % 2) == 1;
      if (iv) r++;
      apply(iv, 0, 32'(400 + r), 0, 0, 0, 0);
      chk($sformatf("stall%0d_swap", k), bus.swap_so, iv && r == 5);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("stall_ret", bus.end_ret, 405);
    chk("stall_cause", bus.swap_cause, 1);
    chk("stall_user", bus.user_mode, 0);
    apply(0, 0, 0, 0, 0, 1, 16'd3);
    apply(1, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      apply(1, 0, 32'(500 + k), k == 3, 0, 0, 0);
      chk($sformatf("both%0d_swap", k), bus.swap_so, k == 3);
    end
    apply(0, 0, 0, 0, 0, 1, 16'd10);
    chk("both_cause", bus.swap_cause, 2);
    chk("both_ret", bus.end_ret, 503);
    apply(1, 0, 0, 0, 1, 0, 0);
    apply(1, 2, 32'd600, 1, 0, 0, 0);
    chk("sc1_swap", bus.swap_so, 1);
    apply(0, 0, 0, 0, 0, 1, 16'd0);
    chk("sc1_ret", bus.end_ret, 600);
    chk("sc1_user", bus.user_mode, 0);
    apply(1, 0, 0, 0, 1, 0, 0);
    swaps = 0;
    for (int k = 0; k < 1000; k++) begin
      apply(1, 0, 32'(1000 + k), 0, 0, 0, 0);
      if (bus.swap_so !== 1'b0) swaps++;
    end
    chk("q0_swaps", swaps, 0);
    chk("q0_user", bus.user_mode, 1);
    do_reset();
    #1;
    chk("mid_rst_user", bus.user_mode, 0);
    chk("mid_rst_ret", bus.end_ret, 0);
    chk("mid_rst_cause", bus.swap_cause, 0);
    apply(0, 0, 0, 0, 0, 1, 16'd4);
    apply(1, 0, 0, 0, 1, 1, 16'd2);
    for (int k = 1; k <= 4; k++) begin
      apply(1, 0, 32'(700 + k), 0, 0, k == 2, 16'd9);
      chk($sformatf("ql%0d_swap", k), bus.swap_so, k == 4);
    end
    apply(1, 0, 0, 0, 1, 0, 0);
    chk("ql_resume_mux", bus.mux_ctrl, 4);
    for (int k = 1; k <= 9; k++) begin
      apply(1, 0, 32'(800 + k), 0, 0, 0, 0);
      chk($sformatf("q9_%0d_swap", k), bus.swap_so, k == 9);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("q9_ret", bus.end_ret, 809);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
